// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one clock-enabled pipelined multiplier between two requesters
module mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               req_a,
    input  logic [WIDTH-1:0]   opa_a,
    input  logic [WIDTH-1:0]   opb_a,
    output logic               gnt_a,
    output logic               rvalid_a,
    output logic [2*WIDTH-1:0] result_a,
    input  logic               req_b,
    input  logic [WIDTH-1:0]   opa_b,
    input  logic [WIDTH-1:0]   opb_b,
    output logic               gnt_b,
    output logic               rvalid_b,
    output logic [2*WIDTH-1:0] result_b,
    output logic [WIDTH-1:0]   mult_dataa,
    output logic [WIDTH-1:0]   mult_datab,
    output logic               mult_en,
    input  logic [2*WIDTH-1:0] mult_result,
    output logic               busy,
    output logic [2:0]         inflight
);
    typedef enum logic {PTR_A, PTR_B} ptr_t;

    ptr_t               rr_q, rr_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] own_q, own_d;
    logic               issue;

    // Grant a lone requester outright; on contention the pointer side wins, then the pointer flips away from the winner
    always_comb begin
        gnt_a      = n_reset & req_a & (~req_b | (rr_q == PTR_A));
        gnt_b      = n_reset & req_b & (~req_a | (rr_q == PTR_B));
        issue      = gnt_a | gnt_b;
        rr_d       = gnt_a ? PTR_B : (gnt_b ? PTR_A : rr_q);
        mult_dataa = gnt_a ? opa_a : (gnt_b ? opa_b : '0);
        mult_datab = gnt_a ? opb_a : (gnt_b ? opb_b : '0);
        mult_en    = issue | (|vld_q);
    end

    // Tag pipeline mirrors the multiplier: it only moves on enabled edges, so tags stay aligned with products
    always_comb begin
        vld_d = vld_q;
        own_d = own_q;
        if (mult_en) begin
            vld_d[0] = issue;
            own_d[0] = gnt_b;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                own_d[i] = own_q[i-1];
            end
        end
    end

    // Last tag stage routes the product to its owner; occupancy is the number of valid tags
    always_comb begin
        rvalid_a = vld_q[LATENCY-1] & ~own_q[LATENCY-1];
        rvalid_b = vld_q[LATENCY-1] & own_q[LATENCY-1];
        result_a = mult_result;
        result_b = mult_result;
        busy     = |vld_q;
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + {2'b00, vld_q[i]};
        end
    end

    // State registers; reset discards every in-flight tag so no stale result is ever reported
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rr_q  <= PTR_A;
            vld_q <= '0;
            own_q <= '0;
        end else begin
            rr_q  <= rr_d;
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench driving a LATENCY=1 and a LATENCY=3 arbiter with the same request stream
module tb_mult_arbiter;
    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    logic        clk;
    logic        n_reset;
    logic        req_a, req_b;
    logic [7:0]  opa_a, opb_a, opa_b, opb_b;
    logic        gnt_a1, gnt_b1, rva1, rvb1, en1, busy1;
    logic        gnt_a3, gnt_b3, rva3, rvb3, en3, busy3;
    logic [15:0] res_a1, res_b1, res_a3, res_b3, mres1, mres3;
    logic [7:0]  da1, db1, da3, db3;
    logic [2:0]  infl1, infl3;
    logic [15:0] p1;
    logic [15:0] p3 [3];
    exp_t        q [4][$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    mult_arbiter #(.WIDTH(8), .LATENCY(1)) u1 (
        .clk(clk), .n_reset(n_reset),
        .req_a(req_a), .opa_a(opa_a), .opb_a(opb_a), .gnt_a(gnt_a1), .rvalid_a(rva1), .result_a(res_a1),
        .req_b(req_b), .opa_b(opa_b), .opb_b(opb_b), .gnt_b(gnt_b1), .rvalid_b(rvb1), .result_b(res_b1),
        .mult_dataa(da1), .mult_datab(db1), .mult_en(en1), .mult_result(mres1),
        .busy(busy1), .inflight(infl1)
    );

    mult_arbiter #(.WIDTH(8), .LATENCY(3)) u3 (
        .clk(clk), .n_reset(n_reset),
        .req_a(req_a), .opa_a(opa_a), .opb_a(opb_a), .gnt_a(gnt_a3), .rvalid_a(rva3), .result_a(res_a3),
        .req_b(req_b), .opa_b(opa_b), .opb_b(opb_b), .gnt_b(gnt_b3), .rvalid_b(rvb3), .result_b(res_b3),
        .mult_dataa(da3), .mult_datab(db3), .mult_en(en3), .mult_result(mres3),
        .busy(busy3), .inflight(infl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Clock-enabled multiplier models, one per pipeline depth
    always @(posedge clk) if (en1) p1 <= {8'b0, da1} * {8'b0, db1};
    always @(posedge clk) begin
        if (en3) begin
            p3[0] <= {8'b0, da3} * {8'b0, db3};
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign mres1 = p1;
    assign mres3 = p3[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic rv, input logic [15:0] res);
        exp_t e;
        if (rv) begin
            if (q[k].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_rvalid%0d at cycle %0d: got rvalid=1 result=%0d expected no result", k, cyc, res);
            end else begin
                e = q[k].pop_front();
                chk($sformatf("due_cycle%0d", k), cyc, e.due);
                chk($sformatf("result%0d", k), {16'b0, res}, {16'b0, e.val});
            end
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest expected product for that port, in the expected cycle
    always @(negedge clk) begin
        mon(0, rva1, res_a1);
        mon(1, rvb1, res_b1);
        mon(2, rva3, res_a3);
        mon(3, rvb3, res_b3);
    end

    task automatic st(input logic ra, input logic [7:0] xa, input logic [7:0] ya, input logic [15:0] pa,
                      input logic rb, input logic [7:0] xb, input logic [7:0] yb, input logic [15:0] pb,
                      input logic ega, input logic egb, input int ei1, input int ei3);
        logic [7:0] ea, eb;
        @(posedge clk);
        #1;
        req_a = ra; opa_a = xa; opb_a = ya;
        req_b = rb; opa_b = xb; opb_b = yb;
        #1;
        ea = ega ? xa : (egb ? xb : 8'd0);
        eb = ega ? ya : (egb ? yb : 8'd0);
        chk("gnt_a1", gnt_a1, ega);
        chk("gnt_b1", gnt_b1, egb);
        chk("gnt_a3", gnt_a3, ega);
        chk("gnt_b3", gnt_b3, egb);
        chk("dataa1", da1, ea);
        chk("datab1", db1, eb);
        chk("dataa3", da3, ea);
        chk("datab3", db3, eb);
        chk("inflight1", infl1, ei1);
        chk("inflight3", infl3, ei3);
        chk("busy1", busy1, ei1 != 0);
        chk("busy3", busy3, ei3 != 0);
        chk("mult_en1", en1, ega | egb | (ei1 != 0));
        chk("mult_en3", en3, ega | egb | (ei3 != 0));
        if (ega) begin
            q[0].push_back('{cyc + 1, pa});
            q[2].push_back('{cyc + 3, pa});
        end
        if (egb) begin
            q[1].push_back('{cyc + 1, pb});
            q[3].push_back('{cyc + 3, pb});
        end
    endtask

    task automatic idle(input int ei1, input int ei3);
        st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ei1, ei3);
    endtask

    initial begin
        n_reset = 1'b0;
        req_a = 1'b1; opa_a = 8'd5; opb_a = 8'd5;
        req_b = 1'b1; opa_b = 8'd6; opb_b = 8'd6;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt_a1", gnt_a1, 0);
        chk("rst_gnt_b3", gnt_b3, 0);
        chk("rst_en1", en1, 0);
        chk("rst_en3", en3, 0);
        chk("rst_dataa3", da3, 0);
        chk("rst_datab1", db1, 0);
        chk("rst_busy3", busy3, 0);
        chk("rst_inflight3", infl3, 0);
        req_a = 1'b0; req_b = 1'b0;
        @(posedge clk);
        #1 n_reset = 1'b1;
        // contention from reset: A first, then alternate
        st(1, 3, 4, 12, 1, 5, 6, 30, 1, 0, 0, 0);
        st(1, 3, 4, 12, 1, 5, 6, 30, 0, 1, 1, 1);
        st(1, 3, 4, 12, 1, 5, 6, 30, 1, 0, 1, 2);
        st(1, 3, 4, 12, 1, 5, 6, 30, 0, 1, 1, 3);
        idle(1, 3);
        idle(0, 2);
        idle(0, 1);
        idle(0, 0);
        idle(0, 0);
        // single op, then idle window with the multiplier frozen
        st(1, 7, 9, 63, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1, 1);
        idle(0, 1);
        idle(0, 1);
        idle(0, 0);
        // back-to-back A ops filling the LATENCY=3 pipe, ending with the largest operands
        st(1, 2, 2, 4, 0, 0, 0, 0, 1, 0, 0, 0);
        st(1, 3, 3, 9, 0, 0, 0, 0, 1, 0, 1, 1);
        st(1, 4, 4, 16, 0, 0, 0, 0, 1, 0, 1, 2);
        st(1, 255, 255, 65025, 0, 0, 0, 0, 1, 0, 1, 3);
        idle(1, 3);
        idle(0, 2);
        idle(0, 1);
        idle(0, 0);
        // pointer now sits on B after the A-only run
        st(1, 1, 1, 1, 1, 16, 16, 256, 0, 1, 0, 0);
        idle(1, 1);
        idle(0, 1);
        idle(0, 1);
        idle(0, 0);
        // two ops in flight, then reset discards them
        st(1, 10, 10, 100, 1, 11, 11, 121, 1, 0, 0, 0);
        st(1, 10, 10, 100, 1, 11, 11, 121, 0, 1, 1, 1);
        @(posedge clk);
        #1;
        n_reset = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        for (int k = 0; k < 4; k++) q[k].delete();
        #1;
        chk("mid_rst_inflight1", infl1, 0);
        chk("mid_rst_inflight3", infl3, 0);
        chk("mid_rst_busy3", busy3, 0);
        chk("mid_rst_rvalid_b1", rvb1, 0);
        @(posedge clk);
        #1 n_reset = 1'b1;
        st(1, 1, 2, 2, 1, 3, 1, 3, 1, 0, 0, 0);
        st(1, 1, 2, 2, 1, 3, 1, 3, 0, 1, 1, 1);
        idle(1, 2);
        idle(0, 2);
        idle(0, 1);
        idle(0, 0);
        idle(0, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("leftover%0d", k), q[k].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
